counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 16, counter datapath width (1..32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base; decode on adr[31:8]==BASE_ADDR[31:8].
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle/strobe/write.
REQ-006 SHALL have ports wbs_sel_i  input  4, wbs_adr_i  input  32, wbs_dat_i  input  32  byte select, address, write data.
REQ-007 SHALL have ports wbs_ack_o  output  1, wbs_dat_o  output  32  ack, read data.
REQ-008 SHALL have port ctr_en  output  1  counter increment enable.
REQ-009 SHALL have port ctr_preset  output  1  counter synchronous load strobe.
REQ-010 SHALL have port ctr_load_value  output  BITS  value loaded on ctr_preset.
REQ-011 SHALL have port ctr_count  input  BITS  current counter value.
REQ-012 SHALL have port irq  output  1  level interrupt.
REQ-013 Counter contract: preset overrides enable; count+1 mod 2^BITS when enabled; holds otherwise.

Function
REQ-014 Registers (offset adr[7:0]): 0x00 CTRL, 0x04 LOAD[BITS-1:0], 0x08 TERM[BITS-1:0], 0x0C STATUS, 0x10 COUNT (RO, =ctr_count zero-extended).
REQ-015 CTRL: bit0 START (write-1 pulse, reads 0), bit1 STOP (write-1 pulse, reads 0), bit2 RELOAD mode, bit3 IRQ_EN.
REQ-016 STATUS: bit0 BUSY (state!=IDLE && state!=DONE, RO), bit1 DONE (sticky, write-1-to-clear), bit[31:16] WRAPS (reload-mode terminal count, saturates at 16'hFFFF, cleared on START).
REQ-017 Access: valid = cyc&stb&address match; ack one cycle after valid, single-cycle; no ack in cycle following an ack; write commits on ack cycle.
REQ-018 Byte lanes: writes honour wbs_sel_i per byte; CTRL/STATUS pulse and W1C bits act only if sel[0] set.
REQ-019 Unmapped offsets within base: acked, reads 0, writes ignored; non-matching address: no ack.
REQ-020 FSM states IDLE, LOAD, RUN, DONE.
REQ-021 IDLE/DONE + START -> LOAD; START in LOAD/RUN ignored.
REQ-022 LOAD: ctr_preset=1, ctr_load_value=LOAD register, ctr_en=0, one cycle, -> RUN.
REQ-023 RUN: ctr_en=1 while ctr_count!=TERM; when ctr_count==TERM: ctr_en=0, DONE bit set, -> DONE (RELOAD=0) or -> LOAD with WRAPS+1 (RELOAD=1).
REQ-024 DONE: ctr_en=0, ctr_preset=0, counter holds TERM.
REQ-025 STOP in any state -> IDLE next cycle, outputs deasserted; STOP wins over START in same write and over terminal detection in same cycle (DONE not set).
REQ-026 LOAD/TERM writes during RUN take effect at next LOAD state; LOAD>TERM counts through wrap 2^BITS-1->0 until equality; LOAD==TERM reaches DONE in first RUN cycle.
REQ-027 irq = DONE & IRQ_EN, combinational from registered bits; W1C write to DONE coincident with set: set wins.
REQ-028 ctr_preset and ctr_en never both 1.

Reset
REQ-029 wb_rst_i asserted SHALL immediately force state IDLE, CTRL/LOAD/TERM/STATUS to 0, wbs_ack_o=0, ctr_en=0, ctr_preset=0, ctr_load_value=0, irq=0, regardless of clock.
REQ-030 Reset mid-transaction SHALL drop the pending ack; first access after deassertion behaves per REQ-017.

Verification
REQ-031 One-shot: LOAD=5, TERM=8, CTRL=0x9 -> 1 preset cycle, 3 ctr_en cycles, count 8, DONE=1, irq=1, BUSY=0.
REQ-032 Reload: LOAD=2, TERM=4, CTRL=0x5 -> repeating preset,en,en,terminal; after 3 periods WRAPS=3, DONE=1, irq=0 (IRQ_EN=0).
REQ-033 Wrap: BITS=16, LOAD=16'hFFFE, TERM=1 -> count FFFE,FFFF,0,1 then DONE.
REQ-034 Collisions: CTRL=0x3 in IDLE -> stays IDLE; STOP on terminal cycle -> IDLE, DONE=0; W1C DONE on set cycle -> DONE stays 1.
REQ-035 Bus: read COUNT during RUN -> live value, ack exactly one cycle after strobe; sel=4'b0010 write to CTRL -> no START; unmapped offset 0x20 -> ack, data 0.
REQ-036 Async reset asserted mid-RUN between clock edges -> ctr_en, irq, ack low before next edge; all registers read 0 after release.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Wishbone-controlled sequencer for an external up-counter. Software writes a
//   preset value (LOAD) and a terminal value (TERM) and issues START. The block
//   presets the counter for one cycle, enables it until it reaches TERM, then
//   either stops (one-shot) or presets again (reload mode, counting wraps).
//
// Ports
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]              byte lane selects
//   wbs_adr_i[31:0]             address; block decoded on adr[31:8]
//   wbs_dat_i[31:0]             write data
//   wbs_ack_o, wbs_dat_o[31:0]  single-cycle ack, read data (valid with ack)
//   ctr_en                      counter increment enable
//   ctr_preset                  counter synchronous load strobe
//   ctr_load_value[BITS-1:0]    value loaded while ctr_preset is high
//   ctr_count[BITS-1:0]         current counter value
//   irq                         level interrupt, DONE & IRQ_EN
//
// Register map (offset adr[7:0])
//   0x00 CTRL   bit0 START (pulse), bit1 STOP (pulse), bit2 RELOAD, bit3 IRQ_EN
//   0x04 LOAD   preset value
//   0x08 TERM   terminal value
//   0x0C STATUS bit0 BUSY, bit1 DONE (W1C), bits31:16 WRAPS
//   0x10 COUNT  live counter value (RO)
module counter_seq_ctrl #(
    parameter int unsigned BITS      = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            ctr_en,
    output logic            ctr_preset,
    output logic [BITS-1:0] ctr_load_value,
    input  logic [BITS-1:0] ctr_count,
    output logic            irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_LOAD   = 8'h04;
    localparam logic [7:0] OFS_TERM   = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_COUNT  = 8'h10;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            ack_q;
    logic            reload_q;
    logic            irq_en_q;
    logic            done_q;
    logic [15:0]     wraps_q;
    logic [BITS-1:0] load_q;
    logic [BITS-1:0] term_q;
    // TERM as sampled in the LOAD state; RUN compares against this copy so a
    // TERM write during RUN only affects the next period.
    logic [BITS-1:0] term_act;

    logic [7:0]      offset;
    logic            valid;
    logic            wr;
    logic            wr_ctrl;
    logic            wr_load;
    logic            wr_term;
    logic            wr_status;
    logic            start_req;
    logic            stop_req;
    logic            start_go;
    logic            term_hit;
    logic            set_done;
    logic            clr_done;
    logic            busy;
    logic [31:0]     wmask;
    logic [BITS-1:0] load_nxt;
    logic [BITS-1:0] term_nxt;
    logic [31:0]     load_ext;
    logic [31:0]     term_ext;
    logic [31:0]     count_ext;
    logic [31:0]     rdata;
    logic            unused_sink;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign offset = wbs_adr_i[7:0];
    assign valid  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Writes land on the edge that ends the ack cycle.
    assign wr        = ack_q & valid & wbs_we_i;
    assign wr_ctrl   = wr & (offset == OFS_CTRL);
    assign wr_load   = wr & (offset == OFS_LOAD);
    assign wr_term   = wr & (offset == OFS_TERM);
    assign wr_status = wr & (offset == OFS_STATUS);

    assign start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
    assign stop_req  = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
    assign clr_done  = wr_status & wbs_sel_i[0] & wbs_dat_i[1];

    assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign load_nxt = (load_q & ~wmask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
    assign term_nxt = (term_q & ~wmask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);

    assign unused_sink = ^{wmask, wbs_dat_i};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign term_hit = (state == ST_RUN) && (ctr_count == term_act);
    // STOP in the same cycle suppresses the terminal event entirely.
    assign set_done = term_hit & ~stop_req;
    assign start_go = start_req & ~stop_req & ((state == ST_IDLE) || (state == ST_DONE));
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);

    always_comb begin
        state_nxt = state;
        if (stop_req) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start_go) state_nxt = ST_LOAD;
                ST_LOAD:          state_nxt = ST_RUN;
                ST_RUN:           if (term_hit) state_nxt = reload_q ? ST_LOAD : ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            ack_q    <= 1'b0;
            reload_q <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            wraps_q  <= '0;
            load_q   <= '0;
            term_q   <= '0;
            term_act <= '0;
        end else begin
            state <= state_nxt;
            // Never ack two cycles in a row, so a held strobe is acked every other cycle.
            ack_q <= valid & ~ack_q;

            if (wr_ctrl && wbs_sel_i[0]) begin
                reload_q <= wbs_dat_i[2];
                irq_en_q <= wbs_dat_i[3];
            end
            if (wr_load) load_q <= load_nxt;
            if (wr_term) term_q <= term_nxt;
            if (state == ST_LOAD) term_act <= term_q;

            // A coincident clear loses to a set.
            if (set_done)      done_q <= 1'b1;
            else if (clr_done) done_q <= 1'b0;

            if (start_go) begin
                wraps_q <= '0;
            end else if (set_done && reload_q && (wraps_q != 16'hFFFF)) begin
                wraps_q <= wraps_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctr_preset     = (state == ST_LOAD);
    assign ctr_en         = (state == ST_RUN) && (ctr_count != term_act);
    assign ctr_load_value = load_q;
    assign irq            = done_q & irq_en_q;
    assign wbs_ack_o      = ack_q;

    always_comb begin
        load_ext  = '0;
        term_ext  = '0;
        count_ext = '0;
        load_ext[BITS-1:0]  = load_q;
        term_ext[BITS-1:0]  = term_q;
        count_ext[BITS-1:0] = ctr_count;
        case (offset)
            OFS_CTRL:   rdata = {28'd0, irq_en_q, reload_q, 2'b00};
            OFS_LOAD:   rdata = load_ext;
            OFS_TERM:   rdata = term_ext;
            OFS_STATUS: rdata = {wraps_q, 14'd0, done_q, busy};
            OFS_COUNT:  rdata = count_ext;
            default:    rdata = '0;
        endcase
    end

    assign wbs_dat_o = ack_q ? rdata : '0;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

    localparam int unsigned BITS = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_LOAD   = BASE + 32'h04;
    localparam logic [31:0] A_TERM   = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_COUNT  = BASE + 32'h10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cyc = 1'b0;
    logic            stb = 1'b0;
    logic            we  = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = '0;
    logic [31:0]     wdat = '0;
    logic            ack;
    logic [31:0]     rdat;
    logic            ctr_en;
    logic            ctr_preset;
    logic [BITS-1:0] ctr_load_value;
    logic [BITS-1:0] cnt;
    logic            irq;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int n_pre = 0;
    int n_en  = 0;
    int n_overlap = 0;
    logic [BITS-1:0] en_log[$];

    counter_seq_ctrl #(.BITS(BITS), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .ctr_en(ctr_en), .ctr_preset(ctr_preset),
        .ctr_load_value(ctr_load_value), .ctr_count(cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    // External counter following the counter contract.
    always @(posedge clk or posedge rst) begin
        if (rst)             cnt <= '0;
        else if (ctr_preset) cnt <= ctr_load_value;
        else if (ctr_en)     cnt <= cnt + 1'b1;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (ctr_preset) n_pre++;
        if (ctr_en) begin
            n_en++;
            en_log.push_back(cnt);
        end
        if (ctr_preset && ctr_en) n_overlap++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One bus access; ack_cyc is the cycle number of the ack cycle.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic acked,
                       output int lat, output int ack_cyc);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; lat = 0; rd = '0; ack_cyc = 0;
        for (int i = 1; i <= 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1; lat = i; rd = rdat; ack_cyc = cyc_n;
            end
        end
        if (acked) begin
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int ack_cyc);
        logic [31:0] rd; logic ak; int lt;
        bus(1'b1, a, d, s, rd, ak, lt, ack_cyc);
        chk("write_ack", {31'd0, ak}, 32'd1);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd, output int ack_cyc,
                          output int lat);
        logic ak;
        bus(1'b0, a, '0, 4'hF, rd, ak, lat, ack_cyc);
        chk("read_ack", {31'd0, ak}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Reference model: cycle x counts from 0 = the preset cycle after START commits.
    // Each period is one preset cycle, d enable cycles and one terminal cycle.
    function automatic int terms_before(input int x, input int d, input bit rl);
        if (rl) return x / (d + 2);
        return (x > d + 1) ? 1 : 0;
    endfunction

    function automatic logic [31:0] ref_status(input int x, input int d, input bit rl);
        int t;
        logic [15:0] w;
        logic busy, done;
        t = terms_before(x, d, rl);
        w = rl ? ((t > 65535) ? 16'hFFFF : 16'(t)) : 16'h0;
        busy = rl ? 1'b1 : (x <= d + 1);
        done = (t > 0);
        return {w, 14'd0, done, busy};
    endfunction

    function automatic logic [31:0] ref_count(input int x, input int d, input bit rl, input int l);
        int p;
        if (x == 0) return 32'd0;
        p = rl ? (x % (d + 2)) : ((x > d + 1) ? d + 1 : x);
        if (p == 0) p = d + 1;
        return 32'((l + p - 1) & 32'hFFFF);
    endfunction

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic ea, input logic [31:0] er);
        vec_t v;
        v.name = nm; v.w = w; v.a = a; v.d = d; v.s = s; v.exp_ack = ea; v.exp_rd = er;
        return v;
    endfunction

    vec_t vt[24];

    initial begin
        logic [31:0] rd, exp;
        logic ak;
        int lt, ac, ns, r, base_pre, base_en, q0, x;
        int l, d;
        bit rl, ie;

        vt[0]  = mk("load_full_wr",  1, A_LOAD,   32'h0000_1234, 4'hF, 1, 0);
        vt[1]  = mk("load_full_rd",  0, A_LOAD,   0,             4'hF, 1, 32'h0000_1234);
        vt[2]  = mk("load_b0_wr",    1, A_LOAD,   32'hABCD_5678, 4'h1, 1, 0);
        vt[3]  = mk("load_b0_rd",    0, A_LOAD,   0,             4'hF, 1, 32'h0000_1278);
        vt[4]  = mk("load_b1_wr",    1, A_LOAD,   32'h0000_9900, 4'h2, 1, 0);
        vt[5]  = mk("load_b1_rd",    0, A_LOAD,   0,             4'hF, 1, 32'h0000_9978);
        vt[6]  = mk("term_rst_rd",   0, A_TERM,   0,             4'hF, 1, 32'h0);
        vt[7]  = mk("term_wr",       1, A_TERM,   32'hFFFF_FFFF, 4'hF, 1, 0);
        vt[8]  = mk("term_trunc_rd", 0, A_TERM,   0,             4'hF, 1, 32'h0000_FFFF);
        vt[9]  = mk("ctrl_wr",       1, A_CTRL,   32'h0000_000C, 4'h1, 1, 0);
        vt[10] = mk("ctrl_rd",       0, A_CTRL,   0,             4'hF, 1, 32'h0000_000C);
        vt[11] = mk("ctrl_sel1_wr",  1, A_CTRL,   32'h0000_FF01, 4'h2, 1, 0);
        vt[12] = mk("ctrl_sel1_rd",  0, A_CTRL,   0,             4'hF, 1, 32'h0000_000C);
        vt[13] = mk("no_start_rd",   0, A_STATUS, 0,             4'hF, 1, 32'h0);
        vt[14] = mk("ctrl_clr_wr",   1, A_CTRL,   32'h0,         4'h1, 1, 0);
        vt[15] = mk("ctrl_clr_rd",   0, A_CTRL,   0,             4'hF, 1, 32'h0);
        vt[16] = mk("unmap_wr",      1, BASE + 32'h20, 32'hDEAD_BEEF, 4'hF, 1, 0);
        vt[17] = mk("unmap_rd",      0, BASE + 32'h20, 0,       4'hF, 1, 32'h0);
        vt[18] = mk("count_rd",      0, A_COUNT,  0,             4'hF, 1, 32'h0);
        vt[19] = mk("miss_rd",       0, 32'h3000_0100, 0,       4'hF, 0, 0);
        vt[20] = mk("miss_wr",       1, 32'h2000_0004, 32'h1111, 4'hF, 0, 0);
        vt[21] = mk("miss_chk_rd",   0, A_LOAD,   0,             4'hF, 1, 32'h0000_9978);
        vt[22] = mk("status_wr",     1, A_STATUS, 32'hFFFF_FFFF, 4'hF, 1, 0);
        vt[23] = mk("status_rd",     0, A_STATUS, 0,             4'hF, 1, 32'h0);

        // Reset state, asserted with no clock edge involved.
        #1 rst = 1'b1;
        #2;
        chk("rst_ack",    {31'd0, ack}, 32'd0);
        chk("rst_en",     {31'd0, ctr_en}, 32'd0);
        chk("rst_preset", {31'd0, ctr_preset}, 32'd0);
        chk("rst_ldval",  32'(ctr_load_value), 32'd0);
        chk("rst_irq",    {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Register access table.
        base_pre = n_pre;
        for (int i = 0; i < 24; i++) begin
            bus(vt[i].w, vt[i].a, vt[i].d, vt[i].s, rd, ak, lt, ac);
            chk({vt[i].name, "_ack"}, {31'd0, ak}, {31'd0, vt[i].exp_ack});
            if (!vt[i].w && vt[i].exp_ack) chk(vt[i].name, rd, vt[i].exp_rd);
        end
        chk("table_no_preset", 32'(n_pre - base_pre), 32'd0);

        // One-shot: LOAD=5, TERM=8, START|IRQ_EN.
        do_reset();
        wr_reg(A_LOAD, 32'd5, 4'hF, ac);
        wr_reg(A_TERM, 32'd8, 4'hF, ac);
        base_pre = n_pre; base_en = n_en;
        wr_reg(A_CTRL, 32'h9, 4'h1, ac);
        repeat (10) @(posedge clk);
        #1;
        chk("oneshot_presets", 32'(n_pre - base_pre), 32'd1);
        chk("oneshot_enables", 32'(n_en - base_en), 32'd3);
        chk("oneshot_count", 32'(cnt), 32'd8);
        chk("oneshot_irq", {31'd0, irq}, 32'd1);
        rd_reg(A_STATUS, rd, ac, lt);
        chk("oneshot_status", rd, 32'h0000_0002);

        // Reload: LOAD=2, TERM=4, START|RELOAD, status read in the 4th period.
        do_reset();
        wr_reg(A_LOAD, 32'd2, 4'hF, ac);
        wr_reg(A_TERM, 32'd4, 4'hF, ac);
        wr_reg(A_CTRL, 32'h5, 4'h1, ac);
        ns = cyc_n;
        repeat (12) @(posedge clk);
        rd_reg(A_STATUS, rd, ac, lt);
        r = ac - ns;
        chk("reload_status", rd, ref_status(r, 2, 1'b1));
        chk("reload_wraps3", {16'd0, rd[31:16]}, 32'd3);
        chk("reload_irq", {31'd0, irq}, 32'd0);
        wr_reg(A_CTRL, 32'h2, 4'h1, ac);

        // Wrap through 2^BITS-1 -> 0.
        do_reset();
        wr_reg(A_LOAD, 32'h0000_FFFE, 4'hF, ac);
        wr_reg(A_TERM, 32'h1, 4'hF, ac);
        q0 = en_log.size();
        wr_reg(A_CTRL, 32'h1, 4'h1, ac);
        repeat (8) @(posedge clk);
        #1;
        chk("wrap_en_cycles", 32'(en_log.size() - q0), 32'd3);
        if (en_log.size() - q0 == 3) begin
            chk("wrap_c0", 32'(en_log[q0]),     32'h0000_FFFE);
            chk("wrap_c1", 32'(en_log[q0 + 1]), 32'h0000_FFFF);
            chk("wrap_c2", 32'(en_log[q0 + 2]), 32'h0000_0000);
        end
        chk("wrap_final", 32'(cnt), 32'd1);
        rd_reg(A_STATUS, rd, ac, lt);
        chk("wrap_status", rd, 32'h0000_0002);

        // START and STOP in one write from IDLE.
        do_reset();
        base_pre = n_pre;
        wr_reg(A_CTRL, 32'h3, 4'h1, ac);
        repeat (3) @(posedge clk);
        #1;
        chk("startstop_presets", 32'(n_pre - base_pre), 32'd0);
        rd_reg(A_STATUS, rd, ac, lt);
        chk("startstop_status", rd, 32'h0);

        // STOP acked on the terminal cycle (LOAD=10, TERM=20 -> terminal at cycle 11).
        do_reset();
        wr_reg(A_LOAD, 32'd10, 4'hF, ac);
        wr_reg(A_TERM, 32'd20, 4'hF, ac);
        wr_reg(A_CTRL, 32'h1, 4'h1, ac);
        ns = cyc_n;
        repeat (10) @(posedge clk);
        wr_reg(A_CTRL, 32'h2, 4'h1, ac);
        chk("stopterm_cycle", 32'(ac - ns), 32'd11);
        rd_reg(A_STATUS, rd, ac, lt);
        chk("stopterm_status", rd, 32'h0);
        chk("stopterm_count", 32'(cnt), 32'd20);

        // W1C of DONE acked on the terminal cycle: set wins.
        do_reset();
        wr_reg(A_LOAD, 32'd10, 4'hF, ac);
        wr_reg(A_TERM, 32'd20, 4'hF, ac);
        wr_reg(A_CTRL, 32'h1, 4'h1, ac);
        ns = cyc_n;
        repeat (10) @(posedge clk);
        wr_reg(A_STATUS, 32'h2, 4'h1, ac);
        exp = ((ac - ns) == 11) ? 32'h2 : 32'h0;
        rd_reg(A_STATUS, rd, ac, lt);
        chk("w1c_collide_status", rd, exp);
        wr_reg(A_STATUS, 32'h2, 4'h1, ac);
        rd_reg(A_STATUS, rd, ac, lt);
        chk("w1c_clear_status", rd, 32'h0);

        // Live COUNT read during RUN.
        do_reset();
        wr_reg(A_LOAD, 32'd100, 4'hF, ac);
        wr_reg(A_TERM, 32'd200, 4'hF, ac);
        wr_reg(A_CTRL, 32'h1, 4'h1, ac);
        ns = cyc_n;
        repeat (5) @(posedge clk);
        rd_reg(A_COUNT, rd, ac, lt);
        chk("count_ack_latency", 32'(lt), 32'd1);
        chk("count_live", rd, ref_count(ac - ns, 100, 1'b0, 100));
        wr_reg(A_CTRL, 32'h2, 4'h1, ac);

        // Async reset between edges during RUN with a read being acked.
        do_reset();
        wr_reg(A_LOAD, 32'd0, 4'hF, ac);
        wr_reg(A_TERM, 32'd3, 4'hF, ac);
        wr_reg(A_CTRL, 32'h9, 4'h1, ac);
        repeat (8) @(posedge clk);
        wr_reg(A_TERM, 32'd1000, 4'hF, ac);
        wr_reg(A_CTRL, 32'h9, 4'h1, ac);
        repeat (4) @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_COUNT; sel = 4'hF;
        @(posedge clk); #1;
        chk("arst_pre_ack", {31'd0, ack}, 32'd1);
        chk("arst_pre_en",  {31'd0, ctr_en}, 32'd1);
        chk("arst_pre_irq", {31'd0, irq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack",    {31'd0, ack}, 32'd0);
        chk("arst_en",     {31'd0, ctr_en}, 32'd0);
        chk("arst_irq",    {31'd0, irq}, 32'd0);
        chk("arst_preset", {31'd0, ctr_preset}, 32'd0);
        chk("arst_ldval",  32'(ctr_load_value), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b0;
        rd_reg(A_CTRL, rd, ac, lt);   chk("arst_ctrl_rd", rd, 32'h0);
        rd_reg(A_LOAD, rd, ac, lt);   chk("arst_load_rd", rd, 32'h0);
        rd_reg(A_TERM, rd, ac, lt);   chk("arst_term_rd", rd, 32'h0);
        rd_reg(A_STATUS, rd, ac, lt); chk("arst_status_rd", rd, 32'h0);

        // Randomized runs against the period model.
        for (int it = 0; it < 25; it++) begin
            do_reset();
            l  = int'($urandom_range(0, 65535));
            d  = int'($urandom_range(0, 12));
            rl = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wr_reg(A_LOAD, 32'(l), 4'hF, ac);
            wr_reg(A_TERM, 32'((l + d) & 32'hFFFF), 4'hF, ac);
            wr_reg(A_CTRL, {28'd0, ie, rl, 2'b01}, 4'h1, ac);
            ns = cyc_n;
            repeat ($urandom_range(0, 3 * (d + 2))) @(posedge clk);
            rd_reg(A_STATUS, rd, ac, lt);
            chk("rand_status", rd, ref_status(ac - ns, d, rl));
            x = cyc_n - ns;
            chk("rand_irq", {31'd0, irq}, {31'd0, ie && (terms_before(x, d, rl) > 0)});
            rd_reg(A_COUNT, rd, ac, lt);
            chk("rand_count", rd, ref_count(ac - ns, d, rl, l));
        end

        chk("preset_en_overlap", 32'(n_overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
